mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_CH, default 2: number of requester channels, range 1..8.
REQ-002 Parameter ADDR_W, default 7: memory word-address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter TIMEOUT, default 16: maximum cycles to wait for m_done, range 2..255.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows.
- sysclk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req_en  in  N_CH  per-channel request valid.
- req_we  in  N_CH  per-channel write enable (1 = write).
- req_addr  in  N_CH*ADDR_W  per-channel address; channel i occupies slice i.
- req_wdata  in  N_CH*DATA_W  per-channel write data; channel i occupies slice i.
- req_done  out  N_CH  one-cycle completion pulse, at most one bit set.
- req_err  out  1  qualifies req_done; 1 = timed out.
- req_rdata  out  DATA_W  read data shared by all channels; valid when req_done is set.
- m_ena  out  1  memory enable.
- m_wea  out  1  memory write enable.
- m_addra  out  ADDR_W  memory address.
- m_dina  out  DATA_W  memory write data.
- m_douta  in  DATA_W  memory read data; valid with m_done.
- m_done  in  1  memory completion pulse.

Function
REQ-006 Requester handshake: the requester SHALL hold req_en, req_we, req_addr and req_wdata stable from assertion until its req_done pulse.
REQ-007 A requester whose req_en is still high in the cycle after its req_done SHALL be treated as issuing a new request.
REQ-008 The FSM SHALL have three states.
- IDLE -> WAIT when any req_en is high; the grant is registered.
- WAIT -> RESP on m_done, or when the timeout counter reaches TIMEOUT-1.
- RESP -> IDLE unconditionally.
REQ-009 Arbitration SHALL be round-robin: the search starts at the channel after the last granted one and wraps from N_CH-1 to 0.
REQ-010 After reset the last-granted pointer SHALL equal N_CH-1, so channel 0 has first priority.
REQ-011 While in WAIT, the block SHALL hold m_ena=1 and drive m_wea, m_addra and m_dina from the granted channel's registered copy; all of these are 0 outside WAIT.
REQ-012 Request inputs SHALL be sampled only in IDLE; changes made during WAIT have no effect.
REQ-013 On m_done in WAIT, the block SHALL capture m_douta into req_rdata.
REQ-014 req_rdata SHALL hold its value until the next capture; writes also capture, and the captured value is don't-care for writes.
REQ-015 In RESP, req_done[grant] SHALL be 1 for exactly one cycle; req_err=1 only if WAIT ended by timeout.
REQ-016 If m_done and the timeout occur in the same cycle, m_done SHALL win: req_err=0 and data is captured.
REQ-017 An m_done arriving outside WAIT SHALL be ignored.
REQ-018 The timeout counter SHALL clear on entry to WAIT, increment each WAIT cycle, and be $clog2(TIMEOUT) bits wide.
REQ-019 Latency SHALL be as follows, with the request sampled in IDLE at cycle 0.
- m_ena is first high in cycle 1.
- An m_done in cycle k gives req_done in cycle k+1.
- The minimum transaction is 3 cycles; back-to-back throughput is 1 transaction per 3+ cycles.
REQ-020 With N_CH=1, the block SHALL behave identically, with a fixed grant of 0.

Reset
REQ-021 When rst=1 at a sysclk edge, the block SHALL do all of the following.
- State goes to IDLE.
- Pointer goes to N_CH-1.
- Counter goes to 0.
- req_done, req_err, req_rdata, m_ena, m_wea, m_addra and m_dina go to 0.
REQ-022 A reset during WAIT or RESP SHALL abandon the transaction silently; no req_done is issued for it.

Structure
REQ-023 A shared package mem_arb_pkg SHALL hold the following.
- The FSM state enum (IDLE, WAIT, RESP).
- Default parameter constants.
REQ-024 Grant selection SHALL be one combinational sub-module, rr_pick, with these ports.
- Inputs: request vector and last-grant pointer.
- Outputs: grant index and any-request flag.

Verification
REQ-025 Single read: the bench SHALL cover this case.
- Stimulus: ch0 reads addr 0x05; memory returns 0xDEADBEEF with m_done 2 cycles after m_ena.
- Required response: req_done=01 one cycle later, req_rdata=0xDEADBEEF, req_err=0.
REQ-026 Contention: the bench SHALL cover this case.
- Stimulus: ch0 and ch1 both request continuously from reset.
- Required response: grants alternate 0,1,0,1; each req_done is a single cycle; m_addra matches the granted channel.
REQ-027 Timeout: the bench SHALL cover this case.
- Stimulus: TIMEOUT=4, ch1 writes, m_done is never asserted.
- Required response: req_done=10 with req_err=1 exactly 5 cycles after the IDLE sample; m_ena then drops.
REQ-028 Tie: the bench SHALL cover this case.
- Stimulus: m_done is asserted in the same cycle the counter reaches TIMEOUT-1.
- Required response: req_err=0 and data captured.
REQ-029 Reset mid-WAIT: the bench SHALL cover this case.
- Stimulus: rst is asserted 1 cycle after m_ena rises.
- Required response: the next cycle shows all outputs 0, no req_done, and the next grant goes to ch0.
REQ-030 Stray m_done: the bench SHALL cover this case.
- Stimulus: m_done pulses while in IDLE.
- Required response: no req_done, and req_rdata is unchanged.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default constants for the
// memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_N_CH    = 2;
  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin grant selection: search starts one
// past the last grant and wraps to channel 0.
module rr_pick #(
  parameter int N_CH = 2,
  parameter int PW   = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   last,
  output logic [PW-1:0]   grant,
  output logic            any
);

  // lowest offset from last wins, so scan offsets high to low
  always_comb begin
    int idx;
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(last) + k) % N_CH;
      if (req[idx]) begin
        grant = PW'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel round-robin arbiter in front of a
// single-port memory with completion timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     sysclk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_en,
  input  logic [N_CH-1:0]          req_we,
  input  logic [N_CH*ADDR_W-1:0]   req_addr,
  input  logic [N_CH*DATA_W-1:0]   req_wdata,
  output logic [N_CH-1:0]          req_done,
  output logic                     req_err,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     m_ena,
  output logic                     m_wea,
  output logic [ADDR_W-1:0]        m_addra,
  output logic [DATA_W-1:0]        m_dina,
  input  logic [DATA_W-1:0]        m_douta,
  input  logic                     m_done
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(TIMEOUT);

  state_t        state;
  logic [PW-1:0] last;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pick;
  logic          any;
  logic          tmo;

  rr_pick #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_pick (
    .req   (req_en),
    .last  (last),
    .grant (pick),
    .any   (any)
  );

  assign tmo = (cnt == CW'(TIMEOUT - 1));

  // arbitration FSM with registered memory and response outputs
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= PW'(N_CH - 1);
      cnt       <= '0;
      req_done  <= '0;
      req_err   <= 1'b0;
      req_rdata <= '0;
      m_ena     <= 1'b0;
      m_wea     <= 1'b0;
      m_addra   <= '0;
      m_dina    <= '0;
    end else begin
      req_done <= '0;
      req_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            state   <= WAIT;
            last    <= pick;
            cnt     <= '0;
            m_ena   <= 1'b1;
            m_wea   <= req_we[pick];
            m_addra <= req_addr[int'(pick)*ADDR_W +: ADDR_W];
            m_dina  <= req_wdata[int'(pick)*DATA_W +: DATA_W];
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (m_done || tmo) begin
            state          <= RESP;
            m_ena          <= 1'b0;
            m_wea          <= 1'b0;
            m_addra        <= '0;
            m_dina         <= '0;
            req_done[last] <= 1'b1;
            req_err        <= ~m_done;
            if (m_done)
              req_rdata <= m_douta;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (2 channels,
// timeout of 4 cycles).
module tb_mem_arbiter;

  localparam int N_CH    = 2;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;

  logic                   sysclk;
  logic                   rst;
  logic [N_CH-1:0]        req_en;
  logic [N_CH-1:0]        req_we;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*DATA_W-1:0] req_wdata;
  logic [N_CH-1:0]        req_done;
  logic                   req_err;
  logic [DATA_W-1:0]      req_rdata;
  logic                   m_ena;
  logic                   m_wea;
  logic [ADDR_W-1:0]      m_addra;
  logic [DATA_W-1:0]      m_dina;
  logic [DATA_W-1:0]      m_douta;
  logic                   m_done;

  int nvec;
  int nerr;

  mem_arbiter #(
    .N_CH    (N_CH),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .req_en    (req_en),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .req_err   (req_err),
    .req_rdata (req_rdata),
    .m_ena     (m_ena),
    .m_wea     (m_wea),
    .m_addra   (m_addra),
    .m_dina    (m_dina),
    .m_douta   (m_douta),
    .m_done    (m_done)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".done"}, 64'(req_done), 64'd0);
    chk({tag, ".err"},  64'(req_err),  64'd0);
    chk({tag, ".ena"},  64'(m_ena),    64'd0);
    chk({tag, ".wea"},  64'(m_wea),    64'd0);
    chk({tag, ".addr"}, 64'(m_addra),  64'd0);
    chk({tag, ".dina"}, 64'(m_dina),   64'd0);
  endtask

  initial begin
    nvec      = 0;
    nerr      = 0;
    rst       = 1'b1;
    req_en    = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    m_douta   = '0;
    m_done    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk_quiet("reset");
    chk("reset.rdata", 64'(req_rdata), 64'd0);

    // single read: ch0 addr 0x05
    req_en   = 2'b01;
    req_addr = {7'h00, 7'h05};
    tick();
    chk("rd.ena",  64'(m_ena),   64'd1);
    chk("rd.wea",  64'(m_wea),   64'd0);
    chk("rd.addr", 64'(m_addra), 64'h05);
    tick();
    chk("rd.nodone", 64'(req_done), 64'd0);
    tick();
    m_done  = 1'b1;
    m_douta = 32'hDEADBEEF;
    tick();
    m_done = 1'b0;
    chk("rd.done",  64'(req_done),  64'h1);
    chk("rd.err",   64'(req_err),   64'd0);
    chk("rd.rdata", 64'(req_rdata), 64'hDEADBEEF);
    chk("rd.enaoff", 64'(m_ena),    64'd0);
    req_en = '0;
    tick();
    chk("rd.pulse", 64'(req_done), 64'd0);

    // stray m_done while idle
    m_done  = 1'b1;
    m_douta = 32'h12345678;
    tick();
    m_done = 1'b0;
    tick();
    chk("stray.done",  64'(req_done),  64'd0);
    chk("stray.ena",   64'(m_ena),     64'd0);
    chk("stray.rdata", 64'(req_rdata), 64'hDEADBEEF);

    // timeout: ch1 write, no m_done
    req_en    = 2'b10;
    req_we    = 2'b10;
    req_addr  = {7'h22, 7'h00};
    req_wdata = {32'hCAFE0001, 32'h0};
    tick();
    chk("to.ena",  64'(m_ena),   64'd1);
    chk("to.wea",  64'(m_wea),   64'd1);
    chk("to.addr", 64'(m_addra), 64'h22);
    chk("to.dina", 64'(m_dina),  64'hCAFE0001);
    tick();
    tick();
    tick();
    chk("to.c4done", 64'(req_done), 64'd0);
    chk("to.c4ena",  64'(m_ena),    64'd1);
    tick();
    chk("to.done", 64'(req_done), 64'h2);
    chk("to.err",  64'(req_err),  64'd1);
    chk("to.ena0", 64'(m_ena),    64'd0);
    req_en = '0;
    req_we = '0;
    tick();
    chk("to.pulse", 64'(req_done), 64'd0);
    chk("to.errclr", 64'(req_err), 64'd0);

    // tie: m_done in the last timeout cycle
    req_en   = 2'b01;
    req_addr = {7'h00, 7'h11};
    tick();
    tick();
    tick();
    tick();
    m_done  = 1'b1;
    m_douta = 32'hA5A5A5A5;
    tick();
    m_done = 1'b0;
    chk("tie.done",  64'(req_done),  64'h1);
    chk("tie.err",   64'(req_err),   64'd0);
    chk("tie.rdata", 64'(req_rdata), 64'hA5A5A5A5);
    req_en = '0;
    tick();

    // contention from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_en   = 2'b11;
    req_addr = {7'h0B, 7'h0A};
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("ct%0d.addr", t), 64'(m_addra),
          (t % 2 == 0) ? 64'h0A : 64'h0B);
      m_done  = 1'b1;
      m_douta = 32'h100 + 32'(t);
      tick();
      m_done = 1'b0;
      chk($sformatf("ct%0d.done", t), 64'(req_done),
          (t % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("ct%0d.rdata", t), 64'(req_rdata),
          64'h100 + 64'(t));
      tick();
      chk($sformatf("ct%0d.pulse", t), 64'(req_done), 64'd0);
    end

    // reset mid-WAIT: ch0 granted, then abandoned
    tick();
    chk("rw.addr", 64'(m_addra), 64'h0A);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_quiet("rw");
    chk("rw.rdata", 64'(req_rdata), 64'd0);
    tick();
    chk("rw.regrant", 64'(m_addra), 64'h0A);
    chk("rw.ena",     64'(m_ena),   64'd1);
    chk("rw.nodone",  64'(req_done), 64'd0);
    m_done  = 1'b1;
    m_douta = 32'h5A5A0000;
    tick();
    m_done = 1'b0;
    req_en = '0;
    chk("rw.done", 64'(req_done), 64'h1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
